pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/pipeline_ctrl_if.sv | 34 +++
 rtl/pipeline_ctrl_sat_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encodings, defaults
// and the packed control-output bundle used by the controller and benches.
package pipeline_ctrl_pkg;

   localparam int FLUSH_DEPTH_DEF = 2;
   localparam int CNT_W_DEF       = 16;
   localparam int FCNT_W          = 3;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_HALT    = 2'd3
   } state_e;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic if_id_flush;
      logic id_ex_bubble;
   } ctl_t;

   localparam ctl_t CTL_RUN    = ctl_t'(6'b1111_00);
   localparam ctl_t CTL_FREEZE = ctl_t'(6'b0000_00);
   localparam ctl_t CTL_FLUSH  = ctl_t'(6'b1111_11);
   localparam ctl_t CTL_STALL  = ctl_t'(6'b0011_01);
   localparam ctl_t CTL_HALTIN = ctl_t'(6'b0111_10);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Core-side request flags and controller-side stage enables/counters.
interface pipeline_ctrl_if
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             hazard;
   logic             branch_taken;
   logic             mem_busy;
   logic             halt_req;
   logic             resume;
   logic             clr_cnt;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output hazard, branch_taken, mem_busy, halt_req, resume, clr_cnt,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
      input  state, stall_cnt, flush_cnt
   );

   modport slave (
      input  hazard, branch_taken, mem_busy, halt_req, resume, clr_cnt,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
      output state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt sequencer with stall and branch-flush counters.
//   state   | meaning
//   RUN     | normal issue; stalls on hazard, starts flush on taken branch
//   MEMWAIT | frozen on data memory; exits as RUN in the same cycle
//   FLUSH   | IF/ID flushed while the flush down-counter runs to zero
//   HALT    | fetch stopped, downstream drains until resume
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input logic            clk,
   input logic            rst_n,
   pipeline_ctrl_if.slave bus
);
   localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_DEPTH - 1);

   state_e            state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   ctl_t              ctl;
   logic              stall_inc;
   logic              flush_inc;
   logic [CNT_W-1:0]  stall_q;
   logic [CNT_W-1:0]  flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_comb begin
      ctl       = CTL_RUN;
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      flush_inc = 1'b0;
      if (bus.mem_busy) begin
         ctl = CTL_FREEZE;
         if (state_q == ST_RUN || state_q == ST_MEMWAIT) begin
            state_d = ST_MEMWAIT;
         end
      end else begin
         case (state_q)
            ST_RUN, ST_MEMWAIT: begin
               state_d = ST_RUN;
               if (bus.branch_taken) begin
                  ctl       = CTL_FLUSH;
                  flush_inc = 1'b1;
                  if (FLUSH_DEPTH > 1) begin
                     fcnt_d  = FLUSH_LOAD;
                     state_d = ST_FLUSH;
                  end
               end else if (bus.hazard) begin
                  ctl = CTL_STALL;
               end else if (bus.halt_req) begin
                  ctl     = CTL_HALTIN;
                  state_d = ST_HALT;
               end
            end
            ST_FLUSH: begin
               ctl = CTL_FLUSH;
               // terminal count: the cycle that takes the counter to zero is the last flush
               if (fcnt_q <= FCNT_W'(1)) begin
                  fcnt_d  = '0;
                  state_d = ST_RUN;
               end else begin
                  fcnt_d = fcnt_q - FCNT_W'(1);
               end
            end
            ST_HALT: begin
               ctl = CTL_STALL;
               if (bus.resume) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
               fcnt_d  = '0;
            end
         endcase
      end
   end

   assign stall_inc = !ctl.pc_en && (state_q != ST_HALT);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .clr   (bus.clr_cnt),
      .count (stall_q)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .clr   (bus.clr_cnt),
      .count (flush_q)
   );

   assign bus.pc_en        = ctl.pc_en;
   assign bus.if_id_en     = ctl.if_id_en;
   assign bus.id_ex_en     = ctl.id_ex_en;
   assign bus.ex_mem_en    = ctl.ex_mem_en;
   assign bus.if_id_flush  = ctl.if_id_flush;
   assign bus.id_ex_bubble = ctl.id_ex_bubble;
   assign bus.state        = state_q;
   assign bus.stall_cnt    = stall_q;
   assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic, all checked
// against a mode-based reference model (halted / flush cycles left / waiting).
module tb_pipeline_ctrl;
   localparam int FLUSH_DEPTH = 2;
   localparam int CNT_W       = 5;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(.FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: current mode and counters
   bit         m_halt;
   bit         m_wait;
   int         m_left;
   int         m_stall;
   int         m_flush;
   // per-cycle results
   logic [5:0] e_ctl;
   bit         n_halt;
   bit         n_wait;
   int         n_left;
   bit         e_stall_inc;
   bit         e_flush_inc;

   function automatic logic [5:0] obs_ctl();
      return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
              bus.if_id_flush, bus.id_ex_bubble};
   endfunction

   function automatic int exp_state();
      if (m_halt)        return 3;
      else if (m_left > 0) return 2;
      else if (m_wait)   return 1;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_halt = 0; m_wait = 0; m_left = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic model_eval(input bit hz, input bit br, input bit mb, input bit hr, input bit rs);
      n_halt = m_halt; n_wait = 0; n_left = m_left; e_flush_inc = 0;
      if (mb) begin
         e_ctl  = 6'b000000;
         n_wait = !m_halt && (m_left == 0);
      end else if (m_halt) begin
         e_ctl = 6'b001101;
         if (rs) n_halt = 0;
      end else if (m_left > 0) begin
         e_ctl  = 6'b111111;
         n_left = m_left - 1;
      end else if (br) begin
         e_ctl       = 6'b111111;
         e_flush_inc = 1;
         n_left      = FLUSH_DEPTH - 1;
      end else if (hz) begin
         e_ctl = 6'b001101;
      end else if (hr) begin
         e_ctl  = 6'b011110;
         n_halt = 1;
      end else begin
         e_ctl = 6'b111100;
      end
      e_stall_inc = !e_ctl[5] && !m_halt;
   endtask

   task automatic model_commit(input bit cc);
      m_halt = n_halt; m_wait = n_wait; m_left = n_left;
      if (cc) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (e_stall_inc && m_stall < CNT_MAX) m_stall++;
         if (e_flush_inc && m_flush < CNT_MAX) m_flush++;
      end
   endtask

   task automatic cycle(input bit hz, input bit br, input bit mb, input bit hr,
                        input bit rs, input bit cc);
      @(negedge clk);
      bus.hazard = hz; bus.branch_taken = br; bus.mem_busy = mb;
      bus.halt_req = hr; bus.resume = rs; bus.clr_cnt = cc;
      #1;
      model_eval(hz, br, mb, hr, rs);
      chk("state", 32'(bus.state), 32'(exp_state()));
      chk("ctl", 32'(obs_ctl()), 32'(e_ctl));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
      @(posedge clk);
      #1;
      model_commit(cc);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      bus.hazard = 0; bus.branch_taken = 0; bus.mem_busy = 0;
      bus.halt_req = 0; bus.resume = 0; bus.clr_cnt = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_ctl", 32'(obs_ctl()), 32'(6'b111100));
      chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
      bus.hazard = 1;
      #1;
      chk("rst_hazard_ctl", 32'(obs_ctl()), 32'(6'b001101));
      bus.hazard = 0;
      @(posedge clk);
      #1;
      chk("rst_hold_state", 32'(bus.state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b1;
      model_reset();
      apply_reset();

      idle(); idle();

      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      chk("hazard2_stall_cnt", 32'(bus.stall_cnt), 32'd2);
      chk("hazard2_state", 32'(bus.state), 32'd0);

      cycle(0, 1, 0, 0, 0, 0);
      chk("branch_state_flush", 32'(bus.state), 32'd2);
      cycle(1, 0, 0, 0, 0, 0);
      chk("branch_back_run", 32'(bus.state), 32'd0);
      chk("branch_flush_cnt", 32'(bus.flush_cnt), 32'd1);

      cycle(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 1, 1, 0, 0);
         chk("flush_frozen_state", 32'(bus.state), 32'd2);
      end
      idle();
      chk("flush_done_state", 32'(bus.state), 32'd0);

      cycle(0, 1, 1, 0, 0, 0);
      chk("memwait_state", 32'(bus.state), 32'd1);
      chk("memwait_flush_cnt", 32'(bus.flush_cnt), 32'd2);
      cycle(0, 1, 0, 0, 0, 0);
      chk("memwait_exit_branch", 32'(bus.flush_cnt), 32'd3);
      chk("memwait_exit_state", 32'(bus.state), 32'd2);
      idle(); idle();

      cycle(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < CNT_MAX + 8; i++) cycle(1, 0, 0, 0, 0, 0);
      chk("stall_saturated", 32'(bus.stall_cnt), 32'(CNT_MAX));
      cycle(0, 0, 0, 1, 0, 0);
      chk("halt_state", 32'(bus.state), 32'd3);
      for (int i = 0; i < 4; i++) idle();
      cycle(0, 0, 0, 0, 1, 0);
      chk("resume_state", 32'(bus.state), 32'd0);
      chk("stall_still_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));
      cycle(0, 0, 0, 0, 0, 1);
      chk("stall_cleared", 32'(bus.stall_cnt), 32'd0);

      cycle(0, 1, 0, 0, 0, 0);
      apply_reset();
      idle();
      chk("reset_abandons_flush", 32'(bus.state), 32'd0);

      cycle(0, 0, 0, 1, 0, 0);
      apply_reset();
      idle();

      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(99) < 30, $urandom_range(99) < 15, $urandom_range(99) < 20,
               $urandom_range(99) < 8, $urandom_range(99) < 30, $urandom_range(99) < 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
